apb_gpio_slave: RTL and testbench
=================================

Name: apb_gpio_slave

Overview:
- APB3-style slave register block that consumes the transactions driven on the team's APB interface and controls an NGPIO-wide GPIO port.
- Provides these functions:
  - direction, output-data and input-data registers;
  - a per-pin interrupt engine (edge or level, selectable polarity) with W1C status;
  - a single registered irq line.
- Sits directly downstream of the APB driver/monitor interface; its pready/prdata/irq outputs are what the monitor samples.

Parameters:
- NGPIO, 8, number of GPIO pins, legal 1..32; register bits above NGPIO-1 read 0 and ignore writes.
- WAIT_STATES, 0, number of access-phase cycles pready is held low before completion, legal 0..15.

Ports:
- pclk  in  1  APB clock; all state on its rising edge.
- preset  in  1  asynchronous, active-high reset.
- psel  in  1  slave select.
- penable  in  1  access-phase strobe.
- pwrite  in  1  1=write, 0=read.
- paddr  in  32  byte address; only paddr[4:2] decoded, paddr[31:5] must be 0 else unmapped.
- pwdata  in  32  write data.
- prdata  out  32  read data, valid when pready=1 on a read.
- pready  out  1  transfer-complete.
- irq  out  1  interrupt, registered.
- gpio_in  in  NGPIO  asynchronous pin inputs.
- gpio_out  out  NGPIO  output data to pads.
- gpio_oe  out  NGPIO  output enable (1=drive).

Behaviour:
- Reset: clock is pclk; reset is asynchronous, active-high (preset). While preset=1:
  - all registers and the wait counter = 0;
  - synchronizers = 0;
  - gpio_out=0, gpio_oe=0, irq=0, prdata=0.
- Register map (offset, access):
  - 0x00 DOUT, RW;
  - 0x04 DIR, RW, 1=output;
  - 0x08 DIN, RO, synchronized gpio_in;
  - 0x0C IEN, RW;
  - 0x10 ITYPE, RW, 1=edge, 0=level;
  - 0x14 IPOL, RW, 1=rising/high, 0=falling/low;
  - 0x18 ISTAT, W1C;
  - 0x1C ID, RO, constant 0x4750_0000 | NGPIO.
- APB phases:
  - setup = psel=1, penable=0;
  - access = psel=1, penable=1.
- Wait counter: wcnt increments each access cycle while wcnt<WAIT_STATES; it clears whenever psel=0 or pready=1.
- pready rule:
  - pready = psel & penable & (wcnt==WAIT_STATES), combinational;
  - pready is 0 in setup, in idle and during reset;
  - with WAIT_STATES=0 a transfer is exactly two cycles.
- Write commit: the write takes effect at the rising edge ending the cycle in which psel&penable&pready&pwrite=1. Only that edge updates state; wait cycles have no side effects.
- Read data:
  - prdata = addressed register whenever psel&penable=1, else 0;
  - unmapped reads return 0;
  - unmapped or RO writes are ignored with no error.
- Outputs: gpio_out=DOUT, gpio_oe=DIR, both registered (they change at the commit edge).
- Input path: 2-flop synchronizer on gpio_in, then a 1-flop delayed copy (prev).
  - gpio_in change before edge k → DIN readable after edge k+1.
- Edge detect per pin:
  - rise = sync & ~prev;
  - fall = ~sync & prev.
- Interrupt set conditions per pin:
  - edge mode: IPOL ? rise : fall;
  - level mode: sync == IPOL.
- ISTAT update:
  - ISTAT[i] sets at the edge after the set condition holds, independent of IEN;
  - a W1C write clears the bits written 1;
  - set has priority over clear in the same cycle;
  - in level mode, status re-sets every cycle while the level persists.
- irq: irq <= |(ISTAT & IEN), one cycle after ISTAT changes.
  - Edge latency: gpio_in rising before edge k → ISTAT=1 after edge k+2 → irq=1 after edge k+3.
- Changing ITYPE/IPOL does not clear ISTAT.
- Mid-operation reset: preset asserted mid-transfer aborts the transfer with no commit; everything returns to reset values immediately.
- Master protocol violations:
  - psel dropping during wait states resets wcnt, with no commit;
  - paddr/pwrite/pwdata are sampled only in the completing cycle.

Decomposition:
- gpio_pkg holds:
  - register offset localparams (DOUT_OFF..ID_OFF);
  - ID_VALUE;
  - typedef enum for register index (paddr[4:2]);
  - MAX_NGPIO=32.
- Sub-module gpio_irq_detect (parameter NGPIO) covers the synchronizer, prev flop, edge/level evaluation and ISTAT set/W1C logic. Its output is ISTAT.
- apb_gpio_slave holds the APB decode, wait counter, RW registers, read mux and the irq flop.

Test Plan:
1. Reset + ID: hold preset 3 cycles, release, read 0x1C → prdata=0x4750_0008, pready same cycle as penable (WAIT_STATES=0), all outputs 0.
2. Output path: write DIR=0xFF, DOUT=0xA5 → gpio_oe=0xFF, gpio_out=0xA5 on the edge after completion; read back 0xA5; write 0x20 (unmapped) then read → 0, DOUT unchanged.
3. Input sync: drive gpio_in=0x3C → DIN reads 0x3C only from the 2nd edge after the change; a 1-cycle glitch between edges may be missed without error.
4. Edge irq: IEN=0x01, ITYPE=0x01, IPOL=0x01; rise gpio_in[0] → ISTAT=0x01 after edge k+2, irq=1 after k+3; W1C 0x01 → ISTAT=0, irq=0 one cycle later; a simultaneous new edge keeps ISTAT=1.
5. Level irq: ITYPE=0, IPOL=0 on pin 3, hold gpio_in[3]=0 → W1C 0x08 does not clear; drive pin high, then W1C → cleared, irq deasserts.
6. Wait states (WAIT_STATES=3): write DOUT=0x5A → pready high on the 4th access cycle, DOUT unchanged before it; assert preset during a wait cycle → no commit, DOUT=0.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared constants and register index type for the APB GPIO slave.
package gpio_pkg;
   localparam int MAX_NGPIO = 32;

   localparam logic [4:0] DOUT_OFF  = 5'h00;
   localparam logic [4:0] DIR_OFF   = 5'h04;
   localparam logic [4:0] DIN_OFF   = 5'h08;
   localparam logic [4:0] IEN_OFF   = 5'h0C;
   localparam logic [4:0] ITYPE_OFF = 5'h10;
   localparam logic [4:0] IPOL_OFF  = 5'h14;
   localparam logic [4:0] ISTAT_OFF = 5'h18;
   localparam logic [4:0] ID_OFF    = 5'h1C;

   localparam logic [31:0] ID_VALUE = 32'h4750_0000;

   typedef enum logic [2:0] {
      REG_DOUT  = 3'd0,
      REG_DIR   = 3'd1,
      REG_DIN   = 3'd2,
      REG_IEN   = 3'd3,
      REG_ITYPE = 3'd4,
      REG_IPOL  = 3'd5,
      REG_ISTAT = 3'd6,
      REG_ID    = 3'd7
   } reg_idx_e;
endpackage

// File: rtl/gpio_irq_detect.sv
// Input synchronizer, edge/level evaluation and W1C interrupt status per pin.
module gpio_irq_detect #(
   parameter int NGPIO = 8
) (
   input  logic             pclk,
   input  logic             preset,
   input  logic [NGPIO-1:0] gpio_in,
   input  logic [NGPIO-1:0] itype,
   input  logic [NGPIO-1:0] ipol,
   input  logic [NGPIO-1:0] w1c_mask,
   output logic [NGPIO-1:0] din,
   output logic [NGPIO-1:0] istat
);
   logic [NGPIO-1:0] r_meta, r_sync, r_prev, r_istat;
   logic [NGPIO-1:0] w_rise, w_fall, w_edge, w_level, w_set;

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_meta <= '0;
         r_sync <= '0;
         r_prev <= '0;
      end else begin
         r_meta <= gpio_in;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign w_rise  = r_sync & ~r_prev;
   assign w_fall  = ~r_sync & r_prev;
   assign w_edge  = (ipol & w_rise) | (~ipol & w_fall);
   assign w_level = ~(r_sync ^ ipol);
   assign w_set   = (itype & w_edge) | (~itype & w_level);

   // Set wins over a simultaneous W1C so no event is lost.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) r_istat <= '0;
      else        r_istat <= (r_istat & ~w1c_mask) | w_set;
   end

   assign din   = r_sync;
   assign istat = r_istat;
endmodule

// File: rtl/apb_gpio_slave.sv
// APB3 slave: decode, wait-state counter, GPIO registers, read mux and irq flop.
module apb_gpio_slave
   import gpio_pkg::*;
#(
   parameter int NGPIO       = 8,
   parameter int WAIT_STATES = 0
) (
   input  logic             pclk,
   input  logic             preset,
   input  logic             psel,
   input  logic             penable,
   input  logic             pwrite,
   input  logic [31:0]      paddr,
   input  logic [31:0]      pwdata,
   output logic [31:0]      prdata,
   output logic             pready,
   output logic             irq,
   input  logic [NGPIO-1:0] gpio_in,
   output logic [NGPIO-1:0] gpio_out,
   output logic [NGPIO-1:0] gpio_oe
);
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   logic [3:0]           r_wcnt;
   logic [NGPIO-1:0]     r_dout, r_dir, r_ien, r_itype, r_ipol;
   logic                 r_irq;
   logic                 w_access, w_ready, w_mapped, w_commit;
   reg_idx_e             w_idx;
   logic [NGPIO-1:0]     w_w1c, w_din, w_istat;
   logic [MAX_NGPIO-1:0] w_rdata;
   logic                 w_unused;

   assign w_access = psel & penable & ~preset;
   assign w_ready  = w_access & (r_wcnt == WS);
   assign w_mapped = (paddr[31:5] == 27'd0);
   assign w_idx    = reg_idx_e'(paddr[4:2]);
   assign w_commit = w_ready & pwrite & w_mapped;
   assign w_w1c    = (w_commit && w_idx == REG_ISTAT) ? pwdata[NGPIO-1:0] : '0;
   assign w_unused = ^{pwdata, paddr[1:0]};

   always_ff @(posedge pclk or posedge preset) begin
      if (preset)                        r_wcnt <= '0;
      else if (!psel || w_ready)         r_wcnt <= '0;
      else if (w_access && r_wcnt < WS)  r_wcnt <= r_wcnt + 4'd1;
   end

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         r_dout  <= '0;
         r_dir   <= '0;
         r_ien   <= '0;
         r_itype <= '0;
         r_ipol  <= '0;
      end else if (w_commit) begin
         case (w_idx)
            REG_DOUT:  r_dout  <= pwdata[NGPIO-1:0];
            REG_DIR:   r_dir   <= pwdata[NGPIO-1:0];
            REG_IEN:   r_ien   <= pwdata[NGPIO-1:0];
            REG_ITYPE: r_itype <= pwdata[NGPIO-1:0];
            REG_IPOL:  r_ipol  <= pwdata[NGPIO-1:0];
            default:   ;
         endcase
      end
   end

   gpio_irq_detect #(.NGPIO(NGPIO)) u_irq (
      .pclk     (pclk),
      .preset   (preset),
      .gpio_in  (gpio_in),
      .itype    (r_itype),
      .ipol     (r_ipol),
      .w1c_mask (w_w1c),
      .din      (w_din),
      .istat    (w_istat)
   );

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) r_irq <= 1'b0;
      else        r_irq <= |(w_istat & r_ien);
   end

   always_comb begin
      w_rdata = '0;
      case (w_idx)
         REG_DOUT:  w_rdata[NGPIO-1:0] = r_dout;
         REG_DIR:   w_rdata[NGPIO-1:0] = r_dir;
         REG_DIN:   w_rdata[NGPIO-1:0] = w_din;
         REG_IEN:   w_rdata[NGPIO-1:0] = r_ien;
         REG_ITYPE: w_rdata[NGPIO-1:0] = r_itype;
         REG_IPOL:  w_rdata[NGPIO-1:0] = r_ipol;
         REG_ISTAT: w_rdata[NGPIO-1:0] = w_istat;
         REG_ID:    w_rdata = ID_VALUE | 32'(NGPIO);
         default:   w_rdata = '0;
      endcase
      if (!w_access || !w_mapped) w_rdata = '0;
   end

   assign prdata   = w_rdata;
   assign pready   = w_ready;
   assign irq      = r_irq;
   assign gpio_out = r_dout;
   assign gpio_oe  = r_dir;
endmodule

// File: tb/tb_apb_gpio_slave.sv
// Bench for apb_gpio_slave: directed scenarios plus random traffic against a reference model.
module tb_apb_gpio_slave;
   logic        pclk = 1'b0;
   logic        preset0, preset3;
   logic        psel0, penable, pwrite;
   logic [31:0] paddr, pwdata, prdata0;
   logic        pready0, irq0;
   logic [7:0]  gpio_in, gpio_out0, gpio_oe0;
   logic        psel3, penable3, pwrite3;
   logic [31:0] paddr3, pwdata3, prdata3;
   logic        pready3, irq3;
   logic [7:0]  gpio_out3, gpio_oe3;

   int n_cmp = 0;
   int n_err = 0;

   always #5 pclk = ~pclk;

   apb_gpio_slave #(.NGPIO(8), .WAIT_STATES(0)) dut0 (
      .pclk(pclk), .preset(preset0), .psel(psel0), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .irq(irq0),
      .gpio_in(gpio_in), .gpio_out(gpio_out0), .gpio_oe(gpio_oe0));

   apb_gpio_slave #(.NGPIO(8), .WAIT_STATES(3)) dut3 (
      .pclk(pclk), .preset(preset3), .psel(psel3), .penable(penable3), .pwrite(pwrite3),
      .paddr(paddr3), .pwdata(pwdata3), .prdata(prdata3), .pready(pready3), .irq(irq3),
      .gpio_in(gpio_in), .gpio_out(gpio_out3), .gpio_oe(gpio_oe3));

   // Reference model for dut0: pins seen two edges late, prev one more edge late.
   logic [7:0] m_dout, m_dir, m_ien, m_itype, m_ipol, m_istat;
   logic [7:0] m_s0, m_s1, m_s2;
   logic       m_irq;

   function automatic logic [7:0] m_set(input logic [7:0] s, input logic [7:0] p,
                                        input logic [7:0] ty, input logic [7:0] po);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) begin
         if (ty[i]) r[i] = po[i] ? (s[i] & ~p[i]) : (~s[i] & p[i]);
         else       r[i] = (s[i] == po[i]);
      end
      return r;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (a[31:5] != 27'd0) return 32'h0;
      case (a[4:2])
         3'd0: return {24'h0, m_dout};
         3'd1: return {24'h0, m_dir};
         3'd2: return {24'h0, m_s1};
         3'd3: return {24'h0, m_ien};
         3'd4: return {24'h0, m_itype};
         3'd5: return {24'h0, m_ipol};
         3'd6: return {24'h0, m_istat};
         default: return 32'h4750_0008;
      endcase
   endfunction

   logic       m_wr;
   logic [7:0] m_clr;
   assign m_wr  = psel0 & penable & pwrite & (paddr[31:5] == 27'd0);
   assign m_clr = (m_wr && paddr[4:2] == 3'd6) ? pwdata[7:0] : 8'h00;

   always @(posedge pclk or posedge preset0) begin
      if (preset0) begin
         m_dout <= 0; m_dir <= 0; m_ien <= 0; m_itype <= 0; m_ipol <= 0;
         m_istat <= 0; m_irq <= 0; m_s0 <= 0; m_s1 <= 0; m_s2 <= 0;
      end else begin
         m_irq   <= |(m_istat & m_ien);
         m_istat <= (m_istat & ~m_clr) | m_set(m_s1, m_s2, m_itype, m_ipol);
         m_s0 <= gpio_in; m_s1 <= m_s0; m_s2 <= m_s1;
         if (m_wr) begin
            case (paddr[4:2])
               3'd0: m_dout  <= pwdata[7:0];
               3'd1: m_dir   <= pwdata[7:0];
               3'd3: m_ien   <= pwdata[7:0];
               3'd4: m_itype <= pwdata[7:0];
               3'd5: m_ipol  <= pwdata[7:0];
               default: ;
            endcase
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic apb0(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       output logic [31:0] rd);
      @(negedge pclk);
      psel0 = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
      #1 check("pready_setup", 32'(pready0), 32'h0);
      @(negedge pclk);
      penable = 1'b1;
      #1 check("pready_access", 32'(pready0), 32'h1);
      rd = prdata0;
      if (!wr) check("rdata", rd, model_read(addr));
      @(negedge pclk);
      psel0 = 1'b0; penable = 1'b0; pwrite = 1'b0;
      #1;
   endtask

   task automatic check_outs0();
      check("gpio_out", 32'(gpio_out0), 32'(m_dout));
      check("gpio_oe", 32'(gpio_oe0), 32'(m_dir));
      check("irq", 32'(irq0), 32'(m_irq));
   endtask

   task automatic apb3_write(input logic [31:0] data, input int stop_at, input logic use_rst,
                             input logic [7:0] exp_out, output int acc);
      @(negedge pclk);
      psel3 = 1'b1; penable3 = 1'b0; paddr3 = 32'h0; pwrite3 = 1'b1; pwdata3 = data;
      #1 check("pready3_setup", 32'(pready3), 32'h0);
      @(negedge pclk);
      penable3 = 1'b1;
      acc = 99;
      for (int i = 1; i <= 20; i++) begin
         #1;
         if (i == stop_at) begin
            acc = i;
            if (use_rst) begin
               preset3 = 1'b1;
               #1;
               check("pready3_in_reset", 32'(pready3), 32'h0);
               check("dout3_in_reset", 32'(gpio_out3), 32'h0);
            end else begin
               psel3 = 1'b0; penable3 = 1'b0;
            end
            break;
         end
         if (pready3) begin
            acc = i;
            break;
         end
         check("dout3_wait", 32'(gpio_out3), 32'(exp_out));
         @(negedge pclk);
      end
      @(negedge pclk);
      psel3 = 1'b0; penable3 = 1'b0; pwrite3 = 1'b0;
      #1;
   endtask

   logic [31:0] rd;
   int          acc;

   initial begin
      preset0 = 1'b1; preset3 = 1'b1;
      psel0 = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; gpio_in = 8'h00;
      psel3 = 0; penable3 = 0; pwrite3 = 0; paddr3 = 0; pwdata3 = 0;

      // Reset and ID
      wait_cyc(3);
      #1;
      check("rst_gpio_out", 32'(gpio_out0), 32'h0);
      check("rst_gpio_oe", 32'(gpio_oe0), 32'h0);
      check("rst_irq", 32'(irq0), 32'h0);
      check("rst_prdata", prdata0, 32'h0);
      check("rst_pready", 32'(pready0), 32'h0);
      @(negedge pclk); preset0 = 1'b0;
      apb0(1'b0, 32'h1C, 32'h0, rd);
      check("id", rd, 32'h4750_0008);
      check("prdata_idle", prdata0, 32'h0);

      // Output path and unmapped access
      apb0(1'b1, 32'h04, 32'hFF, rd);
      apb0(1'b1, 32'h00, 32'hA5, rd);
      check("gpio_oe_ff", 32'(gpio_oe0), 32'hFF);
      check("gpio_out_a5", 32'(gpio_out0), 32'hA5);
      apb0(1'b0, 32'h00, 32'h0, rd);
      check("dout_rb", rd, 32'hA5);
      apb0(1'b1, 32'h20, 32'h77, rd);
      apb0(1'b0, 32'h20, 32'h0, rd);
      check("unmapped_rd", rd, 32'h0);
      apb0(1'b1, 32'h100, 32'h11, rd);
      apb0(1'b0, 32'h00, 32'h0, rd);
      check("dout_kept", rd, 32'hA5);
      apb0(1'b1, 32'h1C, 32'h0, rd);
      apb0(1'b0, 32'h1C, 32'h0, rd);
      check("id_ro", rd, 32'h4750_0008);

      // Input synchronizer latency and a glitch between edges
      @(negedge pclk);
      psel0 = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h08; gpio_in = 8'h3C;
      @(negedge pclk); #1 check("din_k", prdata0, 32'h00);
      @(negedge pclk); #1 check("din_k1", prdata0, 32'h3C);
      gpio_in = 8'hBC; #2 gpio_in = 8'h3C;
      wait_cyc(3); #1 check("din_glitch", prdata0, 32'h3C);
      psel0 = 1'b0; penable = 1'b0;

      // Edge interrupt on pin 0, rising
      apb0(1'b1, 32'h10, 32'hFF, rd);
      apb0(1'b1, 32'h14, 32'hFF, rd);
      gpio_in = 8'h00;
      wait_cyc(4);
      apb0(1'b1, 32'h18, 32'hFF, rd);
      apb0(1'b1, 32'h0C, 32'h01, rd);
      apb0(1'b0, 32'h18, 32'h0, rd);
      check("istat_clear0", rd, 32'h0);
      @(negedge pclk);
      psel0 = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h18; gpio_in = 8'h01;
      for (int c = 0; c < 4; c++) begin
         @(negedge pclk); #1;
         check("edge_istat", prdata0, (c >= 2) ? 32'h1 : 32'h0);
         check("edge_irq", 32'(irq0), (c >= 3) ? 32'h1 : 32'h0);
      end
      psel0 = 1'b0; penable = 1'b0;
      apb0(1'b1, 32'h18, 32'h01, rd);
      check("irq_after_w1c", 32'(irq0), 32'h1);
      @(negedge pclk); #1 check("irq_cleared", 32'(irq0), 32'h0);
      apb0(1'b0, 32'h18, 32'h0, rd);
      check("istat_w1c", rd, 32'h0);
      gpio_in = 8'h00; wait_cyc(4);
      gpio_in = 8'h01; wait_cyc(4);
      apb0(1'b0, 32'h18, 32'h0, rd);
      check("istat_reedge", rd, 32'h1);
      gpio_in = 8'h00; wait_cyc(4);
      gpio_in = 8'h01;
      apb0(1'b1, 32'h18, 32'h01, rd);
      apb0(1'b0, 32'h18, 32'h0, rd);
      check("set_beats_clear", rd, 32'h1);
      check_outs0();

      // Level interrupt on pin 3, active low
      apb0(1'b1, 32'h10, 32'h00, rd);
      apb0(1'b1, 32'h14, 32'h00, rd);
      apb0(1'b1, 32'h0C, 32'h08, rd);
      gpio_in = 8'hF7; wait_cyc(4);
      apb0(1'b1, 32'h18, 32'hFF, rd);
      apb0(1'b0, 32'h18, 32'h0, rd);
      check("level_hold", rd, 32'h08);
      check("level_irq", 32'(irq0), 32'h1);
      gpio_in = 8'hFF; wait_cyc(4);
      apb0(1'b1, 32'h18, 32'h08, rd);
      apb0(1'b0, 32'h18, 32'h0, rd);
      check("level_cleared", rd, 32'h0);
      check("level_irq_off", 32'(irq0), 32'h0);

      // Random traffic against the model
      for (int it = 0; it < 200; it++) begin
         logic [31:0] a;
         if ($urandom_range(0, 2) == 0) gpio_in = 8'($urandom);
         a = {27'd0, 3'($urandom_range(0, 7)), 2'b00};
         if ($urandom_range(0, 15) == 0) a = a | 32'h40;
         if ($urandom_range(0, 1) == 0) apb0(1'b1, a, $urandom, rd);
         else                           apb0(1'b0, a, 32'h0, rd);
         check_outs0();
      end

      // Wait states, psel drop and mid-transfer reset on the WAIT_STATES=3 instance
      @(negedge pclk); preset3 = 1'b0;
      apb3_write(32'h5A, 0, 1'b0, 8'h00, acc);
      check("ws_cycles", 32'(acc), 32'd4);
      check("ws_dout", 32'(gpio_out3), 32'h5A);
      apb3_write(32'h11, 2, 1'b0, 8'h5A, acc);
      check("psel_drop_nocommit", 32'(gpio_out3), 32'h5A);
      apb3_write(32'h22, 0, 1'b0, 8'h5A, acc);
      check("ws_cycles_after_drop", 32'(acc), 32'd4);
      check("ws_dout2", 32'(gpio_out3), 32'h22);
      apb3_write(32'h33, 2, 1'b1, 8'h22, acc);
      @(negedge pclk); preset3 = 1'b0;
      wait_cyc(2); #1;
      check("rst_abort_dout", 32'(gpio_out3), 32'h0);
      check("rst_abort_oe", 32'(gpio_oe3), 32'h0);
      check("rst_abort_irq", 32'(irq3), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
